// File: rtl/boot_loader_pkg.sv
// Shared types and helpers for the boot loader: FSM state encoding, word geometry
// and the running-checksum update.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        LEN_HI  = 3'd0,
        LEN_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        CHK     = 3'd4,
        RUN     = 3'd5,
        ERR     = 3'd6
    } state_e;

    localparam int WORD_BYTES = 2;
    localparam int BYTE_W     = 8;

    function automatic logic [7:0] xor_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and instruction-memory/CPU-control outputs of the boot loader.
// master = upstream source side, slave = loader side.
interface boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_run;
    logic              busy;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
               cpu_run, busy, error, words_loaded
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata,
               cpu_run, busy, error, words_loaded
    );
endinterface

// File: rtl/boot_word_assembler.sv
// Packs two accepted bytes (high first) into a registered big-endian word and
// raises word_done_o for exactly one cycle when the low byte lands.
module boot_word_assembler
    import boot_loader_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [BYTE_W-1:0]            byte_i,
    input  logic                         accept_i,
    input  logic                         lo_sel_i,
    output logic [WORD_BYTES*BYTE_W-1:0] word_o,
    output logic                         word_done_o
);

    logic [BYTE_W-1:0]            hi_q, hi_d;
    logic [WORD_BYTES*BYTE_W-1:0] word_q, word_d;
    logic                         done_q, done_d;

    // Next-state for the high-byte latch, assembled word and done pulse
    always_comb begin
        hi_d   = hi_q;
        word_d = word_q;
        done_d = 1'b0;
        if (accept_i && lo_sel_i) begin
            word_d = {hi_q, byte_i};
            done_d = 1'b1;
        end else if (accept_i) begin
            hi_d = byte_i;
        end else begin
            done_d = 1'b0;
        end
    end

    // Assembler registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q   <= '0;
            word_q <= '0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            word_q <= word_d;
            done_q <= done_d;
        end
    end

    assign word_o      = word_q;
    assign word_done_o = done_q;

endmodule

// File: rtl/boot_loader.sv
// Boot loader: receives a length-prefixed big-endian word image over a byte link, writes it to
// instruction memory from word 0 and releases the CPU. Optional trailing XOR byte: BOOT_CHECKSUM_EN.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    boot_loader_if.slave bus
);

    if (WORD_W != 16) begin : g_bad_word_w
        $error("boot_loader: WORD_W must be 16");
    end

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;
`ifdef BOOT_CHECKSUM_EN
    localparam state_e FINAL_STATE = CHK;
`else
    localparam state_e FINAL_STATE = RUN;
`endif

    state_e            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ready_q, ready_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic              accept_s;
    logic [15:0]       len_s;
    logic              too_long_s;
    logic              last_word_s;
    logic              word_done_s;
    logic [15:0]       word_s;

    assign accept_s    = bus.byte_valid & ready_q;
    assign len_s       = {len_hi_q, bus.byte_data};
    assign too_long_s  = (32'(len_s) > DEPTH);
    assign last_word_s = ((32'(idx_q) + 32'd1) == 32'(len_q));

    boot_word_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .byte_i      (bus.byte_data),
        .accept_i    (accept_s && (state_q == DATA_HI || state_q == DATA_LO)),
        .lo_sel_i    (state_q == DATA_LO),
        .word_o      (word_s),
        .word_done_o (word_done_s)
    );

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= LEN_HI;
            len_hi_q <= 8'd0;
            len_q    <= 16'd0;
            idx_q    <= '0;
            addr_q   <= '0;
            ready_q  <= 1'b0;
            run_q    <= 1'b0;
            busy_q   <= 1'b1;
            err_q    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            xor_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            ready_q  <= ready_d;
            run_q    <= run_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
`ifdef BOOT_CHECKSUM_EN
            xor_q    <= xor_d;
`endif
        end
    end

    // Next-state logic; every transition is gated by an accepted byte
    always_comb begin
        state_d = state_q;
        case (state_q)
            LEN_HI:  state_d = accept_s ? LEN_LO : LEN_HI;
            LEN_LO: begin
                if (!accept_s)             state_d = LEN_LO;
                else if (too_long_s)       state_d = ERR;
                else if (len_s == 16'd0)   state_d = FINAL_STATE;
                else                       state_d = DATA_HI;
            end
            DATA_HI: state_d = accept_s ? DATA_LO : DATA_HI;
            DATA_LO: begin
                if (!accept_s)             state_d = DATA_LO;
                else if (last_word_s)      state_d = FINAL_STATE;
                else                       state_d = DATA_HI;
            end
`ifdef BOOT_CHECKSUM_EN
            CHK: begin
                if (!accept_s)                  state_d = CHK;
                else if (bus.byte_data == xor_q) state_d = RUN;
                else                            state_d = ERR;
            end
`else
            CHK:     state_d = ERR;
`endif
            RUN:     state_d = RUN;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        len_hi_d = (accept_s && state_q == LEN_HI) ? bus.byte_data : len_hi_q;
        len_d    = (accept_s && state_q == LEN_LO) ? len_s : len_q;
        if (accept_s && state_q == DATA_LO) begin
            addr_d = idx_q[ADDR_W-1:0];
            idx_d  = idx_q + (ADDR_W+1)'(1);
        end else begin
            addr_d = addr_q;
            idx_d  = idx_q;
        end
`ifdef BOOT_CHECKSUM_EN
        xor_d = (accept_s && (state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO}))
                ? xor_update(xor_q, bus.byte_data) : xor_q;
`endif
        ready_d = (state_d inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK});
        // Hold cpu_run off while the final write strobe is still on the bus
        run_d   = run_q | ((state_q == RUN) & ~word_done_s);
        busy_d  = ~run_d & (state_d != ERR);
        err_d   = err_q | (state_d == ERR);
    end

    assign bus.byte_ready   = ready_q;
    assign bus.imem_we      = word_done_s;
    assign bus.imem_addr    = addr_q;
    assign bus.imem_wdata   = word_s;
    assign bus.cpu_run      = run_q;
    assign bus.busy         = busy_q;
    assign bus.error        = err_q;
    assign bus.words_loaded = idx_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader (ADDR_W=4): directed frames plus random images and gaps,
// checked against a frame-level model of the expected writes, timing and status.
module tb_boot_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    boot_loader_if #(.ADDR_W(AW)) bus ();

    boot_loader #(.ADDR_W(AW), .WORD_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] obs_q[$];
    logic [7:0]  fr[$];

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) obs_q.push_back({12'd0, bus.imem_addr, bus.imem_wdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_chk();
`ifdef BOOT_CHECKSUM_EN
        logic [7:0] x;
        x = 8'd0;
        foreach (fr[i]) x ^= fr[i];
        fr.push_back(x);
`endif
    endtask

    task automatic build_random(input int n);
        logic [15:0] nn;
        nn = 16'(n);
        fr.delete();
        fr.push_back(nn[15:8]);
        fr.push_back(nn[7:0]);
        for (int i = 0; i < 2 * n; i++) fr.push_back(8'($urandom_range(0, 255)));
        add_chk();
    endtask

    task automatic do_reset();
        bus.byte_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.byte_ready), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd1);
        chk("rst_run",   32'(bus.cpu_run), 32'd0);
        chk("rst_err",   32'(bus.error), 32'd0);
        chk("rst_we",    32'(bus.imem_we), 32'd0);
        chk("rst_words", 32'(bus.words_loaded), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready_rise", 32'(bus.byte_ready), 32'd1);
    endtask

    // Sends fr; returns at the falling edge right after the last accepting rising edge
    task automatic send_frame(input bit gaps, input bit hold);
        int  t;
        bit  acc;
        logic r;
        for (int b = 0; b < fr.size(); b++) begin
            if (gaps) begin
                bus.byte_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = fr[b];
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 20) begin
                r = bus.byte_ready;
                @(posedge clk);
                @(negedge clk);
                acc = (r === 1'b1);
                t++;
            end
            if (!acc) begin
                vectors++;
                miscompares++;
                $error("FAIL accept_timeout: byte %0d not accepted after %0d cycles", b, t);
                bus.byte_valid = 1'b0;
                return;
            end
        end
        if (hold) bus.byte_data = 8'($urandom_range(0, 255));
        else      bus.byte_valid = 1'b0;
    endtask

    task automatic run_check(input string tag, input bit gaps, input bit hold);
        int  n, run_lat, exp_cnt;
        bit  too_long, good;
        logic [31:0] e;
`ifdef BOOT_CHECKSUM_EN
        logic [7:0] x;
`endif
        obs_q.delete();
        n        = int'({fr[0], fr[1]});
        too_long = (n > DEPTH);
        good     = !too_long;
`ifdef BOOT_CHECKSUM_EN
        if (!too_long) begin
            x = 8'd0;
            for (int i = 0; i < 2 + 2 * n; i++) x ^= fr[i];
            good = (fr[2 + 2 * n] == x);
        end
`endif
        send_frame(gaps, hold);
        if (too_long) begin
            chk({tag, "_err_now"},   32'(bus.error), 32'd1);
            chk({tag, "_ready_now"}, 32'(bus.byte_ready), 32'd0);
            chk({tag, "_run_now"},   32'(bus.cpu_run), 32'd0);
        end else begin
            run_lat = (n > 0 && !CHK_EN) ? 2 : 1;
            for (int i = 1; i <= run_lat + 1; i++) begin
                if (i == 1 && run_lat == 2) chk({tag, "_we_last"}, 32'(bus.imem_we), 32'd1);
                chk({tag, "_run_t"},  32'(bus.cpu_run), 32'(good && i > run_lat));
                chk({tag, "_busy_t"}, 32'(bus.busy), 32'(good && i <= run_lat));
                chk({tag, "_err_t"},  32'(bus.error), 32'(!good));
                if (i <= run_lat) @(negedge clk);
            end
        end
        repeat (4) @(negedge clk);
        bus.byte_valid = 1'b0;
        exp_cnt = too_long ? 0 : n;
        chk({tag, "_nwrites"}, 32'(obs_q.size()), 32'(exp_cnt));
        for (int i = 0; i < exp_cnt && i < obs_q.size(); i++) begin
            e = {12'd0, 4'(i), fr[2 + 2 * i], fr[3 + 2 * i]};
            chk({tag, "_write"}, obs_q[i], e);
        end
        chk({tag, "_words"}, 32'(bus.words_loaded), 32'(exp_cnt));
        chk({tag, "_run"},   32'(bus.cpu_run), 32'(good));
        chk({tag, "_err"},   32'(bus.error), 32'(!good));
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;

        do_reset();
        fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        add_chk();
        run_check("t1_two_words", 1'b0, 1'b0);

        do_reset();
        fr = '{8'h00, 8'h00};
        add_chk();
        run_check("t2_empty", 1'b0, 1'b0);

        do_reset();
        fr = '{8'h00, 8'h11};
        run_check("t3_too_long", 1'b0, 1'b1);

        do_reset();
        fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
        send_frame(1'b0, 1'b0);
        chk("t4_words_pre", 32'(bus.words_loaded), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("t4_words_rst", 32'(bus.words_loaded), 32'd0);
        chk("t4_busy_rst",  32'(bus.busy), 32'd1);
        chk("t4_ready_rst", 32'(bus.byte_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("t4_ready_post", 32'(bus.byte_ready), 32'd1);
        fr = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        add_chk();
        run_check("t4_reload", 1'b0, 1'b0);

        do_reset();
        fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        add_chk();
        run_check("t5_gaps_hold", 1'b1, 1'b1);

        for (int k = 0; k < 6; k++) begin
            do_reset();
            build_random((k == 0) ? DEPTH : $urandom_range(0, DEPTH));
            run_check("rand_img", 1'b1, k[0]);
        end

        do_reset();
        build_random(0);
        fr.delete();
        begin
            logic [15:0] nn;
            nn = 16'($urandom_range(DEPTH + 1, 65535));
            fr.push_back(nn[15:8]);
            fr.push_back(nn[7:0]);
        end
        run_check("rand_too_long", 1'b0, 1'b0);

`ifdef BOOT_CHECKSUM_EN
        do_reset();
        fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        add_chk();
        fr[6] = fr[6] ^ 8'h01;
        run_check("t6_bad_chk", 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
